// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- multi-cycle execute-stage ALU.
//
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SR/SL and reserved codes) complete on
// the accepting edge. MUL (shift-add) and DIV/MOD (restoring division) run
// one step per clock and complete exactly WIDTH cycles after the accept.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request, sampled only while busy = 0
//   op              0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 SR, 7 SL,
//                   8 DIV, 9 MOD, others reserved
//   operand_sel     second operand source: 0 = rX, 1 = immediate
//   r0, rX, immediate  operands
//   busy            iterative op in flight; start is ignored
//   done            one-cycle pulse, result/flags valid
//   result          primary result
//   result_hi       upper half of the MUL product, 0 for every other op
//   flag_z/n/c/v/dz zero, negative, carry/borrow/MUL overflow,
//                   signed overflow, divide by zero
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             operand_sel,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] rX,
  input  logic [WIDTH-1:0] immediate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_SR  = 4'd6;
  localparam logic [3:0] OP_SL  = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;
  localparam logic [3:0] OP_MOD = 4'd9;

  // Shift amounts at or beyond this value clear the result.
  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   CNT_INIT = SHW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_ITER
  } state_e;

  state_e           state_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             z_q, n_q, c_q, v_q, dz_q;

  // Operand/working registers of the iterative datapath.
  // MUL: acc_hi_q = partial product high half, acc_lo_q = multiplier/low half.
  // DIV: acc_hi_q = partial remainder,         acc_lo_q = dividend/quotient.
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  logic [SHW-1:0]   cnt_q;

  logic [WIDTH-1:0] op2;
  logic             is_iter_op;
  logic             commit;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  logic [WIDTH-1:0] res_d, hi_d;
  logic             z_d, n_d, c_d, v_d, dz_d;
  logic             known_d;

  assign op2        = operand_sel ? immediate : rX;
  assign is_iter_op = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);

  // A result is written either by an accepted single-cycle op or by the last
  // iteration step.
  assign commit = (state_q == S_IDLE) ? (start && !is_iter_op) : (cnt_q == '0);

  // One iteration step for each algorithm.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    step_hi = '0;
    step_lo = '0;

    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // {carry, hi, lo} right by one.
    mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? b_q : '0)};

    // Restoring division: bring the next dividend bit into the remainder and
    // subtract the divisor when it fits. A zero divisor always "fits", which
    // yields an all-ones quotient and leaves the dividend as the remainder.
    div_rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge     = (div_rem_sh >= {1'b0, b_q});
    // When the subtraction is taken the difference is below the divisor, so
    // the low WIDTH bits carry the whole value.
    div_diff   = div_rem_sh[WIDTH-1:0] - b_q;

    if (op_q == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_rem_sh[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end
  end

  // Value to be written on commit: the final iteration step while iterating,
  // otherwise the single-cycle result of the live inputs.
  always_comb begin
    res_d   = '0;
    hi_d    = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    dz_d    = 1'b0;
    known_d = 1'b1;

    if (state_q == S_ITER) begin
      if (op_q == OP_MUL) begin
        res_d = step_lo;
        hi_d  = step_hi;
        c_d   = |step_hi;
      end else begin
        res_d = (op_q == OP_DIV) ? step_lo : step_hi;
        dz_d  = (b_q == '0);
      end
    end else begin
      case (op)
        OP_ADD: begin
          {c_d, res_d} = {1'b0, r0} + {1'b0, op2};
          v_d = (r0[WIDTH-1] == op2[WIDTH-1]) && (res_d[WIDTH-1] != r0[WIDTH-1]);
        end
        OP_SUB: begin
          // The extra top bit of the difference is the borrow (r0 < op2).
          {c_d, res_d} = {1'b0, r0} - {1'b0, op2};
          v_d = (r0[WIDTH-1] != op2[WIDTH-1]) && (res_d[WIDTH-1] != r0[WIDTH-1]);
        end
        OP_AND:  res_d = r0 & op2;
        OP_OR:   res_d = r0 | op2;
        OP_XOR:  res_d = r0 ^ op2;
        OP_SR:   res_d = (op2 < WIDTH_V) ? (r0 >> op2[SHW-1:0]) : '0;
        OP_SL:   res_d = (op2 < WIDTH_V) ? (r0 << op2[SHW-1:0]) : '0;
        // Reserved codes report result 0 with every flag clear, including Z.
        default: known_d = 1'b0;
      endcase
    end

    z_d = known_d && (res_d == '0);
    n_d = res_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      dz_q        <= 1'b0;
      op_q        <= '0;
      b_q         <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      done_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start && is_iter_op) begin
            state_q  <= S_ITER;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_INIT;
            op_q     <= op;
            b_q      <= op2;
            acc_hi_q <= '0;
            acc_lo_q <= r0;
          end
        end
        S_ITER: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (commit) begin
        done_q      <= 1'b1;
        result_q    <= res_d;
        result_hi_q <= hi_d;
        z_q         <= z_d;
        n_q         <= n_d;
        c_q         <= c_d;
        v_q         <= v_d;
        dz_q        <= dz_d;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_dz   = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- bench for alu_seq at WIDTH=8 (index 0) and WIDTH=16 (index 1).
// A behavioural model (plain arithmetic, a busy countdown) predicts every
// output each cycle; directed cases pin literal results.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_SR  = 4'd6;
  localparam logic [3:0] OP_SL  = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;
  localparam logic [3:0] OP_MOD = 4'd9;
  localparam logic [3:0] OP_RSV = 4'd12;

  // flags = {z, n, c, v, dz}
  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic [4:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmp_en = 1'b0;
  always #5 clk = ~clk;

  logic        start_s [2];
  logic [3:0]  op_s    [2];
  logic        sel_s   [2];
  logic [15:0] r0_s    [2];
  logic [15:0] rx_s    [2];
  logic [15:0] imm_s   [2];

  logic [1:0]  busy_v, done_v, z_v, n_v, c_v, v_v, dz_v;
  logic [7:0]  res8, hi8;
  logic [15:0] res16, hi16;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op(op_s[0]),
    .operand_sel(sel_s[0]), .r0(r0_s[0][7:0]), .rX(rx_s[0][7:0]),
    .immediate(imm_s[0][7:0]), .busy(busy_v[0]), .done(done_v[0]),
    .result(res8), .result_hi(hi8), .flag_z(z_v[0]), .flag_n(n_v[0]),
    .flag_c(c_v[0]), .flag_v(v_v[0]), .flag_dz(dz_v[0])
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op(op_s[1]),
    .operand_sel(sel_s[1]), .r0(r0_s[1]), .rX(rx_s[1]),
    .immediate(imm_s[1]), .busy(busy_v[1]), .done(done_v[1]),
    .result(res16), .result_hi(hi16), .flag_z(z_v[1]), .flag_n(n_v[1]),
    .flag_c(c_v[1]), .flag_v(v_v[1]), .flag_dz(dz_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wid(int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic logic [15:0] msk(int i);
    return (i == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic logic [15:0] dut_res(int i);
    return (i == 0) ? {8'h00, res8} : res16;
  endfunction

  function automatic logic [15:0] dut_hi(int i);
    return (i == 0) ? {8'h00, hi8} : hi16;
  endfunction

  function automatic logic [4:0] dut_flags(int i);
    return {z_v[i], n_v[i], c_v[i], v_v[i], dz_v[i]};
  endfunction

  // Reference arithmetic straight from the operation definitions.
  function automatic exp_t compute(int w, logic [3:0] op, logic [15:0] a, logic [15:0] b);
    exp_t   r;
    longint m, half, x, y, sx, sy, s, t;
    logic   z, n, c, v, dz;
    r = '0; c = 1'b0; v = 1'b0; dz = 1'b0;
    m    = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    x = longint'(a) & m;
    y = longint'(b) & m;
    sx = (x >= half) ? x - (m + 1) : x;
    sy = (y >= half) ? y - (m + 1) : y;
    case (op)
      4'd0: begin
        t = x + y; r.res = 16'(t & m); c = (t > m);
        s = sx + sy; v = (s >= half) || (s < -half);
      end
      4'd1: begin
        t = x - y; r.res = 16'(t & m); c = (x < y);
        s = sx - sy; v = (s >= half) || (s < -half);
      end
      4'd2: r.res = 16'(x & y);
      4'd3: r.res = 16'(x | y);
      4'd4: r.res = 16'(x ^ y);
      4'd5: begin
        t = x * y; r.res = 16'(t & m); r.hi = 16'((t >> w) & m); c = (r.hi != 0);
      end
      4'd6: r.res = (y >= w) ? 16'h0 : 16'(x >> y);
      4'd7: r.res = (y >= w) ? 16'h0 : 16'((x << y) & m);
      4'd8: if (y == 0) begin r.res = 16'(m); dz = 1'b1; end else r.res = 16'(x / y);
      4'd9: if (y == 0) begin r.res = 16'(x); dz = 1'b1; end else r.res = 16'(x % y);
      default: return r;
    endcase
    z = (r.res == 16'h0);
    n = r.res[w-1];
    r.flags = {z, n, c, v, dz};
    return r;
  endfunction

  // Cycle model: an iterative op is pending for exactly w edges after accept.
  logic m_busy [2];
  int   m_cnt  [2];
  logic m_done [2];
  exp_t m_pend [2];
  exp_t m_out  [2];

  always @(posedge clk or negedge rst_n) begin : model
    exp_t r;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_cnt[i] = 0; m_done[i] = 1'b0; m_out[i] = '0; m_pend[i] = '0;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b1; m_out[i] = m_pend[i];
          end
        end else if (start_s[i]) begin
          r = compute(wid(i), op_s[i], r0_s[i], sel_s[i] ? imm_s[i] : rx_s[i]);
          if (op_s[i] == OP_MUL || op_s[i] == OP_DIV || op_s[i] == OP_MOD) begin
            m_busy[i] = 1'b1; m_cnt[i] = wid(i); m_pend[i] = r;
          end else begin
            m_done[i] = 1'b1; m_out[i] = r;
          end
        end
      end
    end
  end

  // Compare every output of both DUTs against the model each cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("w%0d busy", wid(i)),   32'(busy_v[i]),   32'(m_busy[i]));
        check($sformatf("w%0d done", wid(i)),   32'(done_v[i]),   32'(m_done[i]));
        check($sformatf("w%0d result", wid(i)), 32'(dut_res(i)),  32'(m_out[i].res));
        check($sformatf("w%0d hi", wid(i)),     32'(dut_hi(i)),   32'(m_out[i].hi));
        check($sformatf("w%0d flags", wid(i)),  32'(dut_flags(i)), 32'(m_out[i].flags));
      end
    end
  end

  function automatic logic [15:0] pick(int i);
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return msk(i);
      3:       return 16'(32'd1 << (wid(i) - 1));
      4:       return 16'($urandom_range(0, wid(i) + 2));
      default: return 16'($urandom) & msk(i);
    endcase
  endfunction

  // Issue one op, scramble operands while it runs, wait (bounded) for done.
  // lat = edges from accept edge to the edge that raised done.
  task automatic do_op(input int i, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic sel, output int lat);
    @(negedge clk);
    op_s[i] = op; sel_s[i] = sel; r0_s[i] = a & msk(i);
    if (sel) begin imm_s[i] = b & msk(i); rx_s[i] = 16'($urandom) & msk(i); end
    else     begin rx_s[i] = b & msk(i); imm_s[i] = 16'($urandom) & msk(i); end
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    lat = 0;
    while (!done_v[i] && lat < 64) begin
      r0_s[i] = pick(i); rx_s[i] = pick(i); imm_s[i] = pick(i); op_s[i] = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    check($sformatf("w%0d done reached", wid(i)), 32'(done_v[i]), 32'd1);
  endtask

  task automatic directed(input int i, input string tag, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b, input logic sel,
                          input int exp_lat, input logic [15:0] exp_res,
                          input logic [15:0] exp_hi, input logic [4:0] exp_flags);
    int lat;
    do_op(i, op, a, b, sel, lat);
    check($sformatf("w%0d %s latency", wid(i), tag), 32'(lat), 32'(exp_lat));
    check($sformatf("w%0d %s result", wid(i), tag), 32'(dut_res(i)), 32'(exp_res));
    check($sformatf("w%0d %s hi", wid(i), tag), 32'(dut_hi(i)), 32'(exp_hi));
    check($sformatf("w%0d %s flags", wid(i), tag), 32'(dut_flags(i)), 32'(exp_flags));
  endtask

  task automatic run_directed(input int i);
    int          w;
    logic [15:0] m, top;
    w = wid(i); m = msk(i); top = 16'(32'd1 << (w - 1));
    directed(i, "ADD",      OP_ADD, m & 16'hFFF0, 16'h0020, 1'b0, 0, 16'h0010, 16'h0, 5'b00100);
    directed(i, "SUB",      OP_SUB, top, 16'h0001, 1'b1, 0, top - 16'h1, 16'h0, 5'b00010);
    directed(i, "MUL",      OP_MUL, m, m, 1'b1, w, 16'h0001, m - 16'h1, 5'b00100);
    directed(i, "DIV",      OP_DIV, 16'd200, 16'd7, 1'b0, w, 16'd28, 16'h0, 5'b00000);
    directed(i, "MOD",      OP_MOD, 16'd200, 16'd7, 1'b1, w, 16'd4, 16'h0, 5'b00000);
    directed(i, "DIV0",     OP_DIV, 16'd5, 16'd0, 1'b0, w, m, 16'h0, 5'b01001);
    directed(i, "MOD0",     OP_MOD, 16'd5, 16'd0, 1'b1, w, 16'd5, 16'h0, 5'b00001);
    directed(i, "SL1",      OP_SL, top | 16'h1, 16'd1, 1'b1, 0, 16'h0002, 16'h0, 5'b00000);
    directed(i, "SRW",      OP_SR, top | 16'h1, 16'(w), 1'b0, 0, 16'h0000, 16'h0, 5'b10000);
    directed(i, "SL0",      OP_SL, top | 16'h1, 16'd0, 1'b1, 0, top | 16'h1, 16'h0, 5'b01000);
    directed(i, "RESERVED", OP_RSV, 16'h0003, 16'h0003, 1'b0, 0, 16'h0000, 16'h0, 5'b00000);
  endtask

  // start held high through a MUL with changing inputs; then a start in the
  // done cycle must be accepted.
  task automatic run_stream(input int i);
    int          w, pulses;
    logic [15:0] m;
    w = wid(i); m = msk(i); pulses = 0;
    @(negedge clk);
    op_s[i] = OP_MUL; sel_s[i] = 1'b1; r0_s[i] = m; imm_s[i] = m; rx_s[i] = 16'h0;
    start_s[i] = 1'b1;
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      if (done_v[i]) pulses++;
      op_s[i] = 4'($urandom_range(0, 9));
      r0_s[i] = pick(i); rx_s[i] = pick(i); imm_s[i] = pick(i); sel_s[i] = 1'($urandom);
    end
    @(negedge clk);
    check($sformatf("w%0d stream early done pulses", w), 32'(pulses), 32'd0);
    check($sformatf("w%0d stream done", w), 32'(done_v[i]), 32'd1);
    check($sformatf("w%0d stream result", w), 32'(dut_res(i)), 32'd1);
    check($sformatf("w%0d stream hi", w), 32'(dut_hi(i)), 32'(m - 16'h1));
    op_s[i] = OP_ADD; sel_s[i] = 1'b0; r0_s[i] = 16'd3; rx_s[i] = 16'd4;
    @(negedge clk);
    start_s[i] = 1'b0;
    check($sformatf("w%0d back-to-back done", w), 32'(done_v[i]), 32'd1);
    check($sformatf("w%0d back-to-back result", w), 32'(dut_res(i)), 32'd7);
    check($sformatf("w%0d back-to-back hi", w), 32'(dut_hi(i)), 32'd0);
    @(negedge clk);
    check($sformatf("w%0d done single pulse", w), 32'(done_v[i]), 32'd0);
  endtask

  // Reset in the middle of a MUL: outputs clear at once, no done follows.
  task automatic run_reset(input int i);
    int w, pulses, lat;
    w = wid(i); pulses = 0;
    @(negedge clk);
    op_s[i] = OP_MUL; sel_s[i] = 1'b1; r0_s[i] = msk(i); imm_s[i] = msk(i);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    repeat (3) @(negedge clk);
    check($sformatf("w%0d busy before reset", w), 32'(busy_v[i]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check($sformatf("w%0d async reset busy", w), 32'(busy_v[i]), 32'd0);
    check($sformatf("w%0d async reset done", w), 32'(done_v[i]), 32'd0);
    check($sformatf("w%0d async reset result", w), 32'(dut_res(i)), 32'd0);
    check($sformatf("w%0d async reset hi", w), 32'(dut_hi(i)), 32'd0);
    check($sformatf("w%0d async reset flags", w), 32'(dut_flags(i)), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < w + 4; k++) begin
      @(negedge clk);
      if (done_v[i]) pulses++;
    end
    check($sformatf("w%0d done after abort", w), 32'(pulses), 32'd0);
    do_op(i, OP_ADD, 16'h0011, 16'h0022, 1'b0, lat);
    check($sformatf("w%0d post-reset ADD", w), 32'(dut_res(i)), 32'h33);
  endtask

  task automatic run_random(input int i);
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      start_s[i] = ($urandom_range(0, 2) != 0);
      op_s[i]    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                               : 4'($urandom_range(0, 9));
      sel_s[i]   = 1'($urandom);
      r0_s[i]    = pick(i);
      rx_s[i]    = pick(i);
      imm_s[i]   = pick(i);
    end
    @(negedge clk);
    start_s[i] = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; op_s[i] = 4'h0; sel_s[i] = 1'b0;
      r0_s[i] = 16'h0; rx_s[i] = 16'h0; imm_s[i] = 16'h0;
    end
    #3 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("w%0d reset busy", wid(i)), 32'(busy_v[i]), 32'd0);
      check($sformatf("w%0d reset done", wid(i)), 32'(done_v[i]), 32'd0);
      check($sformatf("w%0d reset result", wid(i)), 32'(dut_res(i)), 32'd0);
      check($sformatf("w%0d reset hi", wid(i)), 32'(dut_hi(i)), 32'd0);
      check($sformatf("w%0d reset flags", wid(i)), 32'(dut_flags(i)), 32'd0);
    end
    #2 rst_n = 1'b1;

    for (int i = 0; i < 2; i++) begin
      run_directed(i);
      run_stream(i);
      run_reset(i);
      run_random(i);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the CPU's combinational 8-bit ALU.
- Adds the following over that ALU:
  - configurable data width
  - iterative multiply with full double-width product
  - iterative unsigned divide/modulo
  - status flags
  - start/done handshake
- Sits in the CPU execute stage; the control FSM stalls on busy.

Parameters:
- WIDTH, 8, datapath width in bits (>=2).
- SHW, $clog2(WIDTH), internal shift-amount width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 SR, 7 SL, 8 DIV, 9 MOD; others reserved.
- operand_sel  in  1  0 = rX, 1 = immediate.
- r0  in  WIDTH  first operand.
- rX  in  WIDTH  second operand, register source.
- immediate  in  WIDTH  second operand, immediate source.
- busy  out  1  iterative op in progress; start ignored.
- done  out  1  one-cycle pulse; result/flags valid.
- result  out  WIDTH  primary result.
- result_hi  out  WIDTH  MUL high half; 0 for all other ops.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  carry/borrow/MUL overflow (see below).
- flag_v  out  1  signed overflow (ADD/SUB only).
- flag_dz  out  1  divide by zero (DIV/MOD only).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, result, result_hi and all flags = 0; internal accumulators cleared.
- Operand capture: on the accepting edge, r0 and the muxed second operand (op2) are registered. Later input changes do not affect the op in flight.
- States:
  - IDLE: start=1 at edge N.
    - Single-cycle op: result/flags written at edge N, done=1 for cycle N+1, state stays IDLE.
    - MUL/DIV/MOD: go to ITER, busy=1 from N+1, iteration counter = WIDTH-1.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per edge. When the counter reaches 0 at edge N+WIDTH: write result/flags, done=1, busy=0, state IDLE. Latency is exactly WIDTH cycles from accept to done.
- done is high for exactly one cycle. result and flags hold until the next completion.
- start while busy=1: ignored, no queueing.
- start in the done cycle: accepted (state is IDLE).
- Reserved op with start: done pulses next cycle with result=0, all flags 0.
- Arithmetic (all unsigned modulo 2^WIDTH unless noted):
  - ADD: result = r0+op2; flag_c = carry out; flag_v = signed overflow.
  - SUB: result = r0-op2; flag_c = 1 iff r0 < op2 (borrow); flag_v = signed overflow.
  - AND/OR/XOR: flag_c = 0, flag_v = 0.
  - MUL: 2*WIDTH product; result = low half, result_hi = high half; flag_c = (result_hi != 0).
  - SR/SL: logical shift by op2. If op2 >= WIDTH, result = 0. flag_c = 0.
  - DIV: result = quotient. MOD: result = remainder.
  - Divide by zero: still takes WIDTH cycles. DIV result = all ones; MOD result = r0; flag_dz = 1.
- flag_z and flag_n are computed from result for every op. flag_dz = 0 except on a DIV/MOD by zero.
- rst_n asserted mid-ITER: abort immediately to reset values; no done pulse.

Test Plan:
- WIDTH=8, ADD r0=0xF0, rX=0x20, sel=0 -> done next cycle; result=0x10, C=1, Z=0, V=0. SUB 0x80-0x01 -> 0x7F, V=1, C=0.
- MUL r0=0xFF, imm=0xFF, sel=1 -> busy for 8 cycles, done at cycle 8; result=0x01, result_hi=0xFE, C=1.
- DIV 200/7 -> result=28 after 8 cycles. MOD 200/7 -> result=4. DIV 5/0 -> result=0xFF, dz=1. MOD 5/0 -> result=5, dz=1.
- SL r0=0x81 by 1 -> 0x02. SR by 8 -> 0x00, Z=1. SL by 0 -> 0x81, N=1.
- Drive start every cycle during a MUL, changing operands -> only the first op executes, one done pulse. A back-to-back start in the done cycle is accepted.
- Assert rst_n=0 at ITER cycle 4 -> outputs 0 immediately, no done. After release, an ADD completes normally. Repeat all cases with WIDTH=16 (MUL 0xFFFF*0xFFFF -> hi 0xFFFE, lo 0x0001).
